// File: rtl/threshold_scheduler_pkg.sv
// Shared definitions for the threshold scheduler: FSM state encodings and default widths.
package threshold_scheduler_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ISSUE  = 2'd1;
  localparam state_t ST_WAIT   = 2'd2;
  localparam state_t ST_REPORT = 2'd3;

  localparam int DW_DEFAULT = 16;

endpackage

// File: rtl/threshold_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr, wrapping.
module threshold_scheduler_rr_arbiter #(
  parameter int NCH = 4,
  localparam int CHW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] ptr,
  output logic [NCH-1:0] gnt,
  output logic [CHW-1:0] idx
);

  logic [CHW:0] cand;
  logic         found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = {1'b0, ptr} + (CHW+1)'(k);
      if (cand >= (CHW+1)'(NCH)) cand = cand - (CHW+1)'(NCH);
      if (!found && req[cand[CHW-1:0]]) begin
        found                 = 1'b1;
        gnt[cand[CHW-1:0]]    = 1'b1;
        idx                   = cand[CHW-1:0];
      end
    end
  end

endmodule

// File: rtl/threshold_scheduler.sv
// Shares one threshold unit between NCH sensor channels with 1-deep per-channel
// sample buffers, round-robin issue, done/hit handshake and a timeout abort.
//
// state  | meaning
// IDLE   | load shadow level into active level; pick next pending channel
// ISSUE  | 1-cycle start pulse, frees the channel buffer, arms the timer
// WAIT   | wait for thr_done; timer expiry aborts with err
// REPORT | 1-cycle result strobe; advance round-robin pointer past grant
module threshold_scheduler
  import threshold_scheduler_pkg::*;
#(
  parameter int             NCH       = 4,
  parameter int             DW        = DW_DEFAULT,
  parameter int             TIMEOUT   = 15,
  parameter logic [DW-1:0]  LEVEL_RST = 16'h0100,
  localparam int            CHW       = $clog2(NCH)
) (
  input  logic                update_clk,
  input  logic                rst_n,
  input  logic [NCH-1:0]      smp_valid,
  input  logic [NCH*DW-1:0]   smp_data,
  input  logic                cfg_we,
  input  logic [DW-1:0]       cfg_level,
  input  logic [NCH-1:0]      clr_ovr,
  output logic                thr_start,
  output logic [DW-1:0]       thr_data,
  output logic [DW-1:0]       thr_level,
  input  logic                thr_done,
  input  logic                thr_hit,
  output logic                res_valid,
  output logic [CHW-1:0]      res_ch,
  output logic                res_hit,
  output logic                res_err,
  output logic [NCH-1:0]      overrun,
  output logic                busy
);

  localparam int TW = $clog2(TIMEOUT);

  state_t          state;
  logic [NCH-1:0]  pend;
  logic [NCH-1:0]  overrun_q;
  logic [NCH-1:0]  issue_mask;
  logic [NCH-1:0]  issuing;
  logic [NCH-1:0]  accept;
  logic [NCH-1:0]  dropped;
  logic [NCH-1:0]  gnt;
  logic [CHW-1:0]  idx;
  logic [CHW-1:0]  grant;
  logic [CHW-1:0]  ptr;
  logic [TW-1:0]   timer;
  logic [DW-1:0]   smp_buf [NCH];
  logic [DW-1:0]   data_q;
  logic [DW-1:0]   shadow;
  logic [DW-1:0]   active;
  logic            hit_q;
  logic            err_q;

  threshold_scheduler_rr_arbiter #(.NCH(NCH)) u_arb (
    .req (pend),
    .ptr (ptr),
    .gnt (gnt),
    .idx (idx)
  );

  // The channel being issued has already handed its sample to data_q, so its
  // buffer may take a new sample in the same cycle without an overrun.
  assign issuing = (state == ST_ISSUE) ? issue_mask : '0;
  assign accept  = smp_valid & (~pend | issuing);
  assign dropped = smp_valid & pend & ~issuing;

  always_ff @(posedge update_clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      overrun_q <= '0;
      shadow    <= LEVEL_RST;
      for (int i = 0; i < NCH; i++) smp_buf[i] <= '0;
    end else begin
      pend      <= (pend & ~issuing) | accept;
      overrun_q <= (overrun_q & ~clr_ovr) | dropped;
      if (cfg_we) shadow <= cfg_level;
      for (int i = 0; i < NCH; i++) begin
        if (accept[i]) smp_buf[i] <= smp_data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge update_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant      <= '0;
      issue_mask <= '0;
      ptr        <= '0;
      timer      <= '0;
      data_q     <= '0;
      active     <= LEVEL_RST;
      hit_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          active <= shadow;
          if (|pend) begin
            grant      <= idx;
            issue_mask <= gnt;
            data_q     <= smp_buf[idx];
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer <= TW'(TIMEOUT-1);
          hit_q <= 1'b0;
          err_q <= 1'b0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // done on the terminal-count cycle still counts as a real result
          if (thr_done) begin
            hit_q <= thr_hit;
            state <= ST_REPORT;
          end else if (timer == '0) begin
            err_q <= 1'b1;
            state <= ST_REPORT;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_REPORT: begin
          ptr   <= (grant == CHW'(NCH-1)) ? '0 : grant + 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign thr_start = (state == ST_ISSUE);
  assign thr_data  = data_q;
  assign thr_level = active;
  assign res_valid = (state == ST_REPORT);
  assign res_ch    = grant;
  assign res_hit   = res_valid & hit_q;
  assign res_err   = res_valid & err_q;
  assign overrun   = overrun_q;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_threshold_scheduler.sv
// Directed bench for threshold_scheduler: behavioural scoreboard checked every cycle
// plus hand-computed literal expectations for each scenario.
module tb_threshold_scheduler;

  localparam int NCH     = 4;
  localparam int DW      = 16;
  localparam int CHW     = 2;
  localparam int TIMEOUT = 15;

  logic                update_clk;
  logic                rst_n;
  logic [NCH-1:0]      smp_valid;
  logic [NCH*DW-1:0]   smp_data;
  logic                cfg_we;
  logic [DW-1:0]       cfg_level;
  logic [NCH-1:0]      clr_ovr;
  logic                thr_start;
  logic [DW-1:0]       thr_data;
  logic [DW-1:0]       thr_level;
  logic                thr_done;
  logic                thr_hit;
  logic                res_valid;
  logic [CHW-1:0]      res_ch;
  logic                res_hit;
  logic                res_err;
  logic [NCH-1:0]      overrun;
  logic                busy;

  threshold_scheduler #(
    .NCH(NCH), .DW(DW), .TIMEOUT(TIMEOUT), .LEVEL_RST(16'h0100)
  ) dut (
    .update_clk (update_clk),
    .rst_n      (rst_n),
    .smp_valid  (smp_valid),
    .smp_data   (smp_data),
    .cfg_we     (cfg_we),
    .cfg_level  (cfg_level),
    .clr_ovr    (clr_ovr),
    .thr_start  (thr_start),
    .thr_data   (thr_data),
    .thr_level  (thr_level),
    .thr_done   (thr_done),
    .thr_hit    (thr_hit),
    .res_valid  (res_valid),
    .res_ch     (res_ch),
    .res_hit    (res_hit),
    .res_err    (res_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  int total = 0;
  int bad   = 0;

  initial begin
    update_clk = 1'b0;
    forever #5 update_clk = ~update_clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge update_clk);
    #1;
  endtask

  // Behavioural model: an evaluation is a record with an age counted from its
  // start pulse; the scheduler is free whenever no evaluation is in flight.
  logic [DW-1:0]  m_buf [NCH];
  bit             m_pend [NCH];
  logic [NCH-1:0] m_ovr;
  logic [DW-1:0]  m_shadow, m_active, m_last;
  int             m_ptr;
  bit             ev_on, ev_end, ev_hit, ev_err;
  int             ev_ch, ev_age;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_buf[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_ovr    = '0;
    m_shadow = 16'h0100;
    m_active = 16'h0100;
    m_last   = '0;
    m_ptr    = 0;
    ev_on    = 1'b0;
    ev_end   = 1'b0;
    ev_hit   = 1'b0;
    ev_err   = 1'b0;
    ev_ch    = 0;
    ev_age   = 0;
  endtask

  task automatic model_step();
    bit issuing;
    int ich;
    int c;
    issuing = ev_on && (ev_age == 0);
    ich     = ev_ch;
    if (!ev_on) begin
      m_active = m_shadow;
      for (int k = 0; k < NCH; k++) begin
        c = (m_ptr + k) % NCH;
        if (!ev_on && m_pend[c]) begin
          ev_on  = 1'b1;
          ev_ch  = c;
          ev_age = 0;
          ev_end = 1'b0;
          ev_hit = 1'b0;
          ev_err = 1'b0;
          m_last = m_buf[c];
        end
      end
    end else if (ev_end) begin
      ev_on = 1'b0;
      m_ptr = (ev_ch + 1) % NCH;
    end else if (ev_age == 0) begin
      ev_age = 1;
    end else if (thr_done) begin
      ev_end = 1'b1;
      ev_hit = thr_hit;
    end else if (ev_age == TIMEOUT) begin
      ev_end = 1'b1;
      ev_err = 1'b1;
    end else begin
      ev_age++;
    end
    if (issuing) m_pend[ich] = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (clr_ovr[i]) m_ovr[i] = 1'b0;
      if (smp_valid[i]) begin
        if (!m_pend[i]) begin
          m_pend[i] = 1'b1;
          m_buf[i]  = smp_data[i*DW +: DW];
        end else begin
          m_ovr[i] = 1'b1;
        end
      end
    end
    if (cfg_we) m_shadow = cfg_level;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge update_clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge update_clk);
      if (rst_n) begin
        chk("busy",      32'(busy),      32'(ev_on));
        chk("thr_start", 32'(thr_start), 32'(ev_on && ev_age == 0));
        chk("res_valid", 32'(res_valid), 32'(ev_on && ev_end));
        chk("thr_data",  32'(thr_data),  32'(m_last));
        chk("thr_level", 32'(thr_level), 32'(m_active));
        chk("overrun",   32'(overrun),   32'(m_ovr));
        if (ev_on && ev_end) begin
          chk("res_ch",  32'(res_ch),  32'(ev_ch));
          chk("res_hit", 32'(res_hit), 32'(ev_hit));
          chk("res_err", 32'(res_err), 32'(ev_err));
        end
      end
    end
  end

  // Threshold unit stand-in: answers resp_delay WAIT cycles after each start (0 = never).
  int resp_delay = 1;
  bit resp_hit   = 1'b0;
  int cd         = 0;

  initial begin
    thr_done = 1'b0;
    thr_hit  = 1'b0;
    forever begin
      @(negedge update_clk);
      thr_done = 1'b0;
      thr_hit  = 1'b0;
      if (!rst_n) begin
        cd = 0;
      end else if (thr_start) begin
        cd = resp_delay;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          thr_done = 1'b1;
          thr_hit  = resp_hit;
        end
      end
    end
  end

  // Recorder of observed order (actuals only).
  int            res_q[$];
  logic [DW-1:0] start_q[$];
  int            n_res = 0;

  initial begin
    forever begin
      @(negedge update_clk);
      if (rst_n && res_valid) begin
        res_q.push_back(int'(res_ch));
        n_res++;
      end
      if (rst_n && thr_start) start_q.push_back(thr_data);
    end
  end

  task automatic clear_log();
    res_q.delete();
    start_q.delete();
    n_res = 0;
  endtask

  function automatic logic [31:0] res_at(input int k);
    return (k < res_q.size()) ? 32'(res_q[k]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] start_at(input int k);
    return (k < start_q.size()) ? 32'(start_q[k]) : 32'hFFFF_FFFF;
  endfunction

  task automatic strobe(input logic [NCH-1:0] m, input logic [NCH*DW-1:0] d);
    smp_valid = m;
    smp_data  = d;
    tick();
    smp_valid = '0;
  endtask

  task automatic wait_results(input int n, input int budget);
    int c = 0;
    while (n_res < n && c < budget) begin
      tick();
      c++;
    end
    chk("result_count", 32'(n_res), 32'(n));
  endtask

  task automatic wait_start(input int budget);
    int c = 0;
    while (!thr_start && c < budget) begin
      tick();
      c++;
    end
    chk("start_seen", 32'(thr_start), 32'd1);
  endtask

  task automatic measure_latency(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!res_valid && n < 40);
  endtask

  int lat;
  int base;

  initial begin
    rst_n     = 1'b0;
    smp_valid = '0;
    smp_data  = '0;
    cfg_we    = 1'b0;
    cfg_level = '0;
    clr_ovr   = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_level",     32'(thr_level), 32'h0100);
    chk("rst_overrun",   32'(overrun),   32'd0);
    chk("rst_thr_data",  32'(thr_data),  32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);

    // all channels at once from a fresh pointer, then the wrap back to ch0
    resp_delay = 1;
    resp_hit   = 1'b0;
    clear_log();
    strobe(4'hF, {16'h1003, 16'h1002, 16'h1001, 16'h1000});
    wait_results(4, 60);
    for (int k = 0; k < 4; k++) begin
      chk("rr_order",      res_at(k),   32'(k));
      chk("rr_start_data", start_at(k), 32'h1000 + 32'(k));
    end
    tick();
    clear_log();
    strobe(4'b1001, {16'h2003, 16'h0000, 16'h0000, 16'h2000});
    wait_results(2, 40);
    chk("wrap_first",  res_at(0), 32'd0);
    chk("wrap_second", res_at(1), 32'd3);
    tick();

    // single sample on ch2: start two cycles later, result four cycles after sample
    resp_hit = 1'b1;
    clear_log();
    strobe(4'b0100, {16'h0000, 16'h0200, 16'h0000, 16'h0000});
    tick();
    chk("single_start", 32'(thr_start), 32'd1);
    chk("single_data",  32'(thr_data),  32'h0200);
    tick();
    tick();
    chk("single_valid", 32'(res_valid), 32'd1);
    chk("single_ch",    32'(res_ch),    32'd2);
    chk("single_hit",   32'(res_hit),   32'd1);
    chk("single_err",   32'(res_err),   32'd0);
    repeat (3) tick();

    // overrun on ch1 while ch0 is in flight
    resp_hit = 1'b0;
    clear_log();
    strobe(4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h00A0});
    strobe(4'b0010, {16'h0000, 16'h0000, 16'h0011, 16'h0000});
    strobe(4'b0010, {16'h0000, 16'h0000, 16'h0022, 16'h0000});
    chk("ovr_set", 32'(overrun), 32'h2);
    wait_results(2, 40);
    chk("ovr_eval0", start_at(0), 32'h00A0);
    chk("ovr_eval1", start_at(1), 32'h0011);
    clr_ovr = 4'b0010;
    tick();
    clr_ovr = '0;
    chk("ovr_clear", 32'(overrun), 32'h0);
    tick();

    // set beats clear; then a sample landing on the issuing channel is accepted
    clear_log();
    strobe(4'b0010, {16'h0000, 16'h0000, 16'h0033, 16'h0000});
    clr_ovr = 4'b0010;
    strobe(4'b0010, {16'h0000, 16'h0000, 16'h0044, 16'h0000});
    clr_ovr = '0;
    chk("ovr_set_wins", 32'(overrun), 32'h2);
    chk("ovr_issue_now", 32'(thr_start), 32'd1);
    clr_ovr = 4'b0010;
    strobe(4'b0010, {16'h0000, 16'h0000, 16'h0055, 16'h0000});
    clr_ovr = '0;
    chk("ovr_issue_capture", 32'(overrun), 32'h0);
    wait_results(2, 40);
    chk("ovr_eval_33", start_at(0), 32'h0033);
    chk("ovr_eval_55", start_at(1), 32'h0055);
    tick();

    // timeout without done, done on the final wait cycle, done just too late
    resp_delay = 0;
    resp_hit   = 1'b1;
    strobe(4'b1000, {16'hBEEF, 16'h0000, 16'h0000, 16'h0000});
    wait_start(10);
    measure_latency(lat);
    chk("to_latency", 32'(lat),     32'd16);
    chk("to_err",     32'(res_err), 32'd1);
    chk("to_hit",     32'(res_hit), 32'd0);
    chk("to_ch",      32'(res_ch),  32'd3);
    tick();
    resp_delay = 15;
    strobe(4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h0777});
    wait_start(10);
    measure_latency(lat);
    chk("last_done_latency", 32'(lat),     32'd16);
    chk("last_done_err",     32'(res_err), 32'd0);
    chk("last_done_hit",     32'(res_hit), 32'd1);
    tick();
    resp_delay = 16;
    strobe(4'b0010, {16'h0000, 16'h0000, 16'h0888, 16'h0000});
    wait_start(10);
    measure_latency(lat);
    chk("late_done_latency", 32'(lat),     32'd16);
    chk("late_done_err",     32'(res_err), 32'd1);
    chk("late_done_hit",     32'(res_hit), 32'd0);
    repeat (2) tick();

    // level written mid-evaluation only takes effect after an idle cycle
    resp_delay = 5;
    resp_hit   = 1'b0;
    strobe(4'b0100, {16'h0000, 16'h0050, 16'h0000, 16'h0000});
    wait_start(10);
    tick();
    tick();
    cfg_we    = 1'b1;
    cfg_level = 16'h0300;
    tick();
    cfg_we = 1'b0;
    chk("lvl_hold_wait", 32'(thr_level), 32'h0100);
    measure_latency(lat);
    chk("lvl_hold_report", 32'(thr_level), 32'h0100);
    tick();
    tick();
    chk("lvl_new", 32'(thr_level), 32'h0300);

    // reset in the middle of a wait
    resp_delay = 0;
    strobe(4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h0AAA});
    strobe(4'b0010, {16'h0000, 16'h0000, 16'h0111, 16'h0000});
    strobe(4'b0010, {16'h0000, 16'h0000, 16'h0222, 16'h0000});
    tick();
    chk("pre_rst_busy",    32'(busy),    32'd1);
    chk("pre_rst_overrun", 32'(overrun), 32'h2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",      32'(busy),      32'd0);
    chk("mid_rst_start",     32'(thr_start), 32'd0);
    chk("mid_rst_valid",     32'(res_valid), 32'd0);
    chk("mid_rst_overrun",   32'(overrun),   32'd0);
    chk("mid_rst_thr_data",  32'(thr_data),  32'd0);
    chk("mid_rst_level",     32'(thr_level), 32'h0100);
    tick();
    rst_n = 1'b1;
    base  = n_res;
    repeat (20) tick();
    chk("post_rst_no_result", 32'(n_res - base), 32'd0);
    chk("post_rst_idle",      32'(busy),         32'd0);
    chk("post_rst_level",     32'(thr_level),    32'h0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

endmodule
